// File: rtl/ecc_apb_ctrl_if.sv
// APB slave bus bundle for ecc_apb_ctrl.
// Signals: PADDR/PWDATA/PENABLE/PSEL/PWRITE driven by the master,
// PRDATA driven by the slave. No PREADY: every access is zero-wait.
interface ecc_apb_ctrl_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PENABLE;
  logic                       PSEL;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PRDATA;

  modport master (output PADDR, PWDATA, PENABLE, PSEL, PWRITE, input PRDATA);
  modport slave  (input PADDR, PWDATA, PENABLE, PSEL, PWRITE, output PRDATA);
endinterface

// File: rtl/ecc_apb_ctrl.sv
// APB-programmed controller for an ECC core.
// Ports:
//   clk, rst            - single clock, synchronous active-low reset
//   apb                 - APB slave (CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC)
//   core_start          - one-cycle start pulse (high during START)
//   core_ctrl/_data_in/_width/_noise - operands latched when leaving START
//   core_data_out/_num_err/_done     - core result, done is a one-cycle pulse
//   data_out, num_of_errors          - registered result, held until next DONE
//   operation_done                   - high for exactly the DONE cycle
// A CTRL write (value != 3) in IDLE launches an operation. The core gets 5 WAIT
// cycles to answer before the controller gives up and reports 0 data, 2 errors.
module ecc_apb_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_ctrl_if.slave         apb,
  output logic                  core_start,
  output logic [1:0]            core_ctrl,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [1:0]            core_width,
  output logic [DATA_WIDTH-1:0] core_noise,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_num_err,
  input  logic                  core_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // last WAIT cycle index before timing out (5 cycles: 0..4)
  localparam logic [2:0] WAIT_LAST = 3'd4;

  logic [1:0]            state;
  logic [2:0]            wait_cnt;
  logic [1:0]            ctrl_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic [1:0]            width_q;
  logic [DATA_WIDTH-1:0] noise_q;

  logic [3:0] off;
  logic       wr, wr_ctrl, wr_data, wr_width, wr_noise;

  // values the registers will hold after this edge, so a write landing on the
  // START edge is what the core sees
  logic [1:0]            ctrl_nxt;
  logic [DATA_WIDTH-1:0] data_in_nxt;
  logic [1:0]            width_nxt;
  logic [DATA_WIDTH-1:0] noise_nxt;

  assign off      = apb.PADDR[3:0];
  assign wr       = apb.PSEL && apb.PENABLE && apb.PWRITE;
  assign wr_ctrl  = wr && (off == 4'h0);
  assign wr_data  = wr && (off == 4'h4);
  assign wr_width = wr && (off == 4'h8);
  assign wr_noise = wr && (off == 4'hC);

  assign ctrl_nxt    = wr_ctrl  ? apb.PWDATA[1:0]            : ctrl_q;
  assign data_in_nxt = wr_data  ? apb.PWDATA[DATA_WIDTH-1:0] : data_in_q;
  assign width_nxt   = wr_width ? apb.PWDATA[1:0]            : width_q;
  assign noise_nxt   = wr_noise ? apb.PWDATA[DATA_WIDTH-1:0] : noise_q;

  // upper address bits are deliberately not decoded
  logic unused_addr;
  assign unused_addr = ^apb.PADDR[AMBA_ADDR_WIDTH-1:4];

  // register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= '0;
      data_in_q <= '0;
      width_q   <= '0;
      noise_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_nxt;
      data_in_q <= data_in_nxt;
      width_q   <= width_nxt;
      noise_q   <= noise_nxt;
    end
  end

  // read mux, combinational, zero outside a read
  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (off)
        4'h0:    apb.PRDATA[1:0]            = ctrl_q;
        4'h4:    apb.PRDATA[DATA_WIDTH-1:0] = data_in_q;
        4'h8:    apb.PRDATA[1:0]            = width_q;
        4'hC:    apb.PRDATA[DATA_WIDTH-1:0] = noise_q;
        default: apb.PRDATA = '0;
      endcase
    end
  end

  assign core_start     = (state == START);
  assign operation_done = (state == DONE);

  // sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      core_ctrl     <= '0;
      core_data_in  <= '0;
      core_width    <= '0;
      core_noise    <= '0;
      data_out      <= '0;
      num_of_errors <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ctrl && (apb.PWDATA[1:0] != 2'd3)) state <= START;
        end
        START: begin
          core_ctrl    <= ctrl_nxt;
          core_data_in <= data_in_nxt;
          core_width   <= width_nxt;
          core_noise   <= noise_nxt;
          wait_cnt     <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            data_out      <= core_data_out;
            // a count of 3 means "uncorrectable", reported as 2
            num_of_errors <= (core_num_err == 2'd3) ? 2'd2 : core_num_err;
            state         <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            data_out      <= '0;
            num_of_errors <= 2'd2;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Directed bench for ecc_apb_ctrl: APB register access, normal/timeout/
// saturated-error operations, writes during WAIT, CTRL=3, reset abort.
module tb_ecc_apb_ctrl;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int WW = 32;

  logic          clk = 0;
  logic          rst = 0;
  logic          core_start;
  logic [1:0]    core_ctrl;
  logic [DW-1:0] core_data_in;
  logic [1:0]    core_width;
  logic [DW-1:0] core_noise;
  logic [DW-1:0] core_data_out = '0;
  logic [1:0]    core_num_err  = '0;
  logic          core_done     = 0;
  logic [DW-1:0] data_out;
  logic          operation_done;
  logic [1:0]    num_of_errors;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_base;
  int lat;

  ecc_apb_ctrl_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW)) apb ();

  ecc_apb_ctrl #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW)) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .core_start(core_start), .core_ctrl(core_ctrl), .core_data_in(core_data_in),
    .core_width(core_width), .core_noise(core_noise),
    .core_data_out(core_data_out), .core_num_err(core_num_err), .core_done(core_done),
    .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (operation_done) n_done <= n_done + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
  endtask

  // returns at the negedge after the write edge
  task automatic apb_wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(negedge clk);
    apb.PSEL = 1; apb.PWRITE = 1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 0;
    @(negedge clk);
    apb.PENABLE = 1;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic apb_rd(input logic [AW-1:0] a, output logic [WW-1:0] d);
    @(negedge clk);
    apb.PSEL = 1; apb.PWRITE = 0; apb.PADDR = a; apb.PENABLE = 0;
    @(negedge clk);
    apb.PENABLE = 1;
    #1 d = apb.PRDATA;
    @(negedge clk);
    idle_bus();
  endtask

  // counts negedges from the current one until operation_done is seen
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!operation_done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!operation_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [WW-1:0] rd;

  initial begin
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_nerr", num_of_errors, 0);
    chk("rst_opdone", operation_done, 0);
    chk("rst_core_start", core_start, 0);
    rst = 1;
    apb_rd(20'h0, rd);
    chk("rst_ctrl_rd", rd, 0);

    // normal encode, core answers in the second WAIT cycle
    apb_wr(20'h4, 32'hA5);
    apb_wr(20'h8, 32'h0);
    n_base = n_done;
    apb_wr(20'h0, 32'h0);               // state START now
    chk("start_pulse", core_start, 1);
    @(negedge clk);                      // first WAIT cycle
    chk("start_one_cycle", core_start, 0);
    chk("core_data_in", core_data_in, 32'hA5);
    chk("core_width", core_width, 0);
    @(negedge clk);                      // second WAIT cycle
    core_done = 1; core_data_out = 32'h1234; core_num_err = 2'd0;
    @(negedge clk);
    core_done = 0;
    chk("enc_opdone", operation_done, 1);
    chk("enc_data_out", data_out, 32'h1234);
    chk("enc_nerr", num_of_errors, 0);
    @(negedge clk);
    chk("enc_opdone_width", operation_done, 0);
    chk("enc_pulses", n_done - n_base, 1);

    // register readback
    apb_wr(20'hC, 32'h80000001);
    apb_rd(20'hC, rd);  chk("rd_noise", rd, 32'h80000001);
    apb_rd(20'h10, rd); chk("rd_0x10", rd, 0);
    apb_rd(20'h4, rd);  chk("rd_data_in", rd, 32'hA5);
    apb_rd(20'h6, rd);  chk("rd_0x6", rd, 0);

    // timeout: DONE is entered 6 edges after the write edge, sampled at the 7th
    apb_wr(20'h8, 32'h2);
    apb_wr(20'h0, 32'h1);
    wait_done(12, lat);
    chk("to_latency", lat, 6);
    chk("to_data_out", data_out, 0);
    chk("to_nerr", num_of_errors, 2);
    chk("to_core_ctrl", core_ctrl, 1);
    chk("to_core_noise", core_noise, 32'h80000001);
    chk("to_core_width", core_width, 2);

    // core reports 3 errors in the first WAIT cycle (minimum latency)
    apb_wr(20'h0, 32'h2);
    @(negedge clk);
    core_done = 1; core_data_out = 32'hBEEF; core_num_err = 2'd3;
    @(negedge clk);
    core_done = 0;
    chk("n3_opdone_min", operation_done, 1);
    chk("n3_nerr", num_of_errors, 2);
    chk("n3_data_out", data_out, 32'hBEEF);

    // reset while in WAIT, then a stray core_done
    @(negedge clk);
    n_base = n_done;
    apb_wr(20'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    core_done = 1; core_data_out = 32'h5555; core_num_err = 2'd1;
    @(negedge clk);
    core_done = 0;
    repeat (8) @(negedge clk);
    chk("rstw_pulses", n_done - n_base, 0);
    chk("rstw_data_out", data_out, 0);
    chk("rstw_nerr", num_of_errors, 0);
    chk("rstw_core_data", core_data_in, 0);
    chk("rstw_core_noise", core_noise, 0);
    apb_rd(20'hC, rd); chk("rstw_noise_reg", rd, 0);

    // CTRL=3 is stored but never starts
    n_base = n_done;
    apb_wr(20'h0, 32'h3);
    chk("c3_no_start", core_start, 0);
    repeat (9) @(negedge clk);
    chk("c3_pulses", n_done - n_base, 0);
    apb_rd(20'h0, rd); chk("c3_ctrl_rd", rd, 3);

    // writes during WAIT neither restart nor reach the core outputs
    apb_wr(20'h4, 32'h11);
    n_base = n_done;
    apb_wr(20'h0, 32'h0);
    @(negedge clk);
    apb_wr(20'h0, 32'h1);
    apb_wr(20'h4, 32'h22);
    repeat (14) @(negedge clk);
    chk("ww_pulses", n_done - n_base, 1);
    chk("ww_core_data", core_data_in, 32'h11);
    chk("ww_core_ctrl", core_ctrl, 0);
    apb_rd(20'h0, rd); chk("ww_ctrl_rd", rd, 1);
    apb_rd(20'h4, rd); chk("ww_data_rd", rd, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
